// File: rtl/mux_n_stream_reg_if.sv
// Handshake bundle for mux_n_stream_reg: N input channels in, one registered stream out.
`timescale 1ns/100ps
interface mux_n_stream_reg_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_chan;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_n_stream_reg.sv
// N-to-1 registered stream mux, external select (MODE 0) or round-robin (MODE 1).
// Define MUXN_XFER_CNT_EN to add the 16-bit accepted-transfer counter port xfer_cnt.
`timescale 1ns/100ps
module mux_n_stream_reg #(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = 0
) (
    input logic               clk,
    input logic               rst,
    mux_n_stream_reg_if.slave bus
`ifdef MUXN_XFER_CNT_EN
    ,
    output logic [15:0]       xfer_cnt
`endif
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] g;
    logic          gv;
    logic [SW-1:0] rr_ptr;
    logic [N-1:0]  rdy;
    logic [W-1:0]  sel_data;
    logic          load;
    logic          accept;
    logic [W-1:0]  data_q;
    logic [SW-1:0] chan_q;
    logic          valid_q;
    int            idx;

    assign load = !valid_q || bus.out_ready;

    // Round-robin scans from rr_ptr upward with wraparound; first valid wins.
    always_comb begin
        g   = '0;
        gv  = 1'b0;
        idx = 0;
        if (MODE == 0) begin
            g  = bus.sel;
            gv = (int'(bus.sel) < N);
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!gv && bus.in_valid[idx]) begin
                    g  = SW'(idx);
                    gv = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdy      = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = load && gv && (g == SW'(i));
            if (g == SW'(i)) sel_data = bus.in_data[i*W +: W];
        end
    end

    assign accept       = |(rdy & bus.in_valid);
    assign bus.in_ready = rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else if (load) begin
            if (accept) begin
                valid_q <= 1'b1;
                data_q  <= sel_data;
                chan_q  <= g;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (MODE == 1 && accept)
            rr_ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
    end

`ifdef MUXN_XFER_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_cnt <= '0;
        else if (accept)
            xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_mux_n_stream_reg.sv
// Scoreboard bench: expected words queued at issue, popped by per-instance output monitors.
`timescale 1ns/100ps
module tb_mux_n_stream_reg;
    typedef struct {
        logic [2:0]  chan;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    mux_n_stream_reg_if #(.N(4), .W(32)) if0();
    mux_n_stream_reg_if #(.N(4), .W(32)) if1();
    mux_n_stream_reg_if #(.N(6), .W(32)) if2();

`ifdef MUXN_XFER_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    mux_n_stream_reg #(.N(4), .W(32), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0)
`ifdef MUXN_XFER_CNT_EN
        , .xfer_cnt(cnt0)
`endif
    );
    mux_n_stream_reg #(.N(4), .W(32), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1)
`ifdef MUXN_XFER_CNT_EN
        , .xfer_cnt(cnt1)
`endif
    );
    mux_n_stream_reg #(.N(6), .W(32), .MODE(0)) u2 (.clk(clk), .rst(rst), .bus(if2)
`ifdef MUXN_XFER_CNT_EN
        , .xfer_cnt(cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitors: a word is consumed on each cycle with out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && if0.out_valid && if0.out_ready) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL u0_unexpected: got chan %0d data %0h, expected none", if0.out_chan, if0.out_data);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_data", 64'(if0.out_data), 64'(e.data));
                check("u0_chan", 64'(if0.out_chan), 64'(e.chan));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL u1_unexpected: got chan %0d data %0h, expected none", if1.out_chan, if1.out_data);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1_data", 64'(if1.out_data), 64'(e.data));
                check("u1_chan", 64'(if1.out_chan), 64'(e.chan));
            end
        end
    end

    initial begin
        rst = 1'b1;
        if0.in_data = '0; if0.in_valid = '0; if0.sel = '0; if0.out_ready = 1'b0;
        if1.in_data = '0; if1.in_valid = '0; if1.sel = '0; if1.out_ready = 1'b0;
        if2.in_data = '0; if2.in_valid = '0; if2.sel = '0; if2.out_ready = 1'b0;
        #12 rst = 1'b0;
        tick();

        check("rst_valid", 64'(if0.out_valid), 64'd0);
        check("rst_data",  64'(if0.out_data),  64'd0);
        check("rst_chan",  64'(if0.out_chan),  64'd0);
        check("rst_valid1", 64'(if1.out_valid), 64'd0);

        // External select, single word straight through
        if0.sel = 2'd2;
        if0.in_data[2*32 +: 32] = 32'hDEADBEEF;
        if0.in_valid = 4'b0100;
        if0.out_ready = 1'b1;
        #1 check("t1_in_ready", 64'(if0.in_ready), 64'b0100);
        q0.push_back('{3'd2, 32'hDEADBEEF});
        tick();
        check("t1_out_valid", 64'(if0.out_valid), 64'd1);
        if0.in_valid = '0;
        tick();
        check("t1_drained", 64'(if0.out_valid), 64'd0);

        // Stall: held word must not move, ch1 waits, then loads on the release edge
        if0.out_ready = 1'b0;
        if0.sel = 2'd0;
        if0.in_data[0 +: 32] = 32'hA5A5_0001;
        if0.in_valid = 4'b0001;
        q0.push_back('{3'd0, 32'hA5A5_0001});
        tick();
        if0.in_data[32 +: 32] = 32'hB0B0_0002;
        if0.in_valid = 4'b0010;
        if0.sel = 2'd1;
        repeat (3) begin
            #1;
            check("t2_stall_ready", 64'(if0.in_ready), 64'd0);
            check("t2_stall_data",  64'(if0.out_data), 64'hA5A5_0001);
            tick();
        end
        if0.out_ready = 1'b1;
        #1 check("t2_release_ready", 64'(if0.in_ready), 64'b0010);
        q0.push_back('{3'd1, 32'hB0B0_0002});
        tick();
        check("t2_no_bubble", 64'(if0.out_valid), 64'd1);
        if0.in_valid = '0;
        tick();
        tick();

        // Out-of-range select with N=6: nothing granted, held word drains
        if2.sel = 3'd4;
        if2.in_data[4*32 +: 32] = 32'hC0FFEE04;
        if2.in_valid = 6'b010000;
        if2.out_ready = 1'b0;
        tick();
        check("t3_loaded", 64'(if2.out_valid), 64'd1);
        if2.sel = 3'd7;
        if2.in_valid = 6'b111111;
        #1 check("t3_ready_stall", 64'(if2.in_ready), 64'd0);
        if2.out_ready = 1'b1;
        #1 check("t3_ready_load", 64'(if2.in_ready), 64'd0);
        tick();
        check("t3_valid_fall", 64'(if2.out_valid), 64'd0);
        check("t3_data_kept",  64'(if2.out_data),  64'hC0FFEE04);
        check("t3_chan_kept",  64'(if2.out_chan),  64'd4);
        if2.in_valid = '0;

        // Round-robin: all valid, then sparse from rr_ptr=2
        for (int i = 0; i < 4; i++) if1.in_data[i*32 +: 32] = 32'h100 + 32'(i);
        if1.in_valid = 4'b1111;
        if1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            q1.push_back('{3'(k % 4), 32'h100 + 32'(k % 4)});
            tick();
        end
        if1.in_valid = 4'b1010;
        q1.push_back('{3'd3, 32'h103}); tick();
        q1.push_back('{3'd1, 32'h101}); tick();
        q1.push_back('{3'd3, 32'h103}); tick();
        if1.in_valid = '0;
        tick();

        // Async reset mid-stream discards the held word and rewinds rr_ptr
        if1.in_valid = 4'b0001;
        if1.out_ready = 1'b0;
        tick();
        check("t5_held", 64'(if1.out_valid), 64'd1);
        if1.in_valid = '0;
        #2 rst = 1'b1;
        #0.5;
        check("t5_rst_valid", 64'(if1.out_valid), 64'd0);
        check("t5_rst_data",  64'(if1.out_data),  64'd0);
        check("t5_rst_chan",  64'(if1.out_chan),  64'd0);
        #0.5 rst = 1'b0;
        tick();
        if1.in_valid = 4'b1111;
        if1.out_ready = 1'b1;
        q1.push_back('{3'd0, 32'h100});
        tick();
        if1.in_valid = '0;
        tick();

`ifdef MUXN_XFER_CNT_EN
        check("t6_cnt_start", 64'(cnt0), 64'd0);
        check("t6_cnt_u1",    64'(cnt1), 64'd1);
        if0.sel = 2'd0;
        if0.in_data[0 +: 32] = 32'hE0E0_E0E0;
        if0.in_valid = 4'b0001;
        if0.out_ready = 1'b1;
        repeat (10) begin
            q0.push_back('{3'd0, 32'hE0E0_E0E0});
            tick();
        end
        check("t6_cnt_10", 64'(cnt0), 64'd10);
        repeat (65525) begin
            q0.push_back('{3'd0, 32'hE0E0_E0E0});
            tick();
        end
        check("t6_cnt_max", 64'(cnt0), 64'hFFFF);
        q0.push_back('{3'd0, 32'hE0E0_E0E0});
        tick();
        check("t6_cnt_wrap", 64'(cnt0), 64'd0);
        if0.in_valid = '0;
        tick();
`endif

        tick();
        check("q0_empty", 64'(q0.size()), 64'd0);
        check("q1_empty", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
